// File: rtl/acc_bank.sv
// Multi-accumulator bank: in-place LOAD/ADD/SUB/CLR/SHL1/SAR1 on the selected entry,
// registered status flags, and a one-deep shadow bank for context save/restore/swap.
module acc_bank #(
    parameter  int NBITS_D = 16,
    parameter  int N_ACC   = 4,
    parameter  bit SAT_EN  = 1'b0,
    localparam int NSEL    = $clog2(N_ACC)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NSEL-1:0]    i_sel,
    input  logic               i_wr,
    input  logic [2:0]         i_op,
    input  logic [NBITS_D-1:0] i_data,
    input  logic               i_save,
    input  logic               i_restore,
    output logic [NBITS_D-1:0] o_acc,
    output logic               o_zero,
    output logic               o_neg,
    output logic               o_ovf
);

    localparam int MSB = NBITS_D - 1;

    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_CLR  = 3'b100;
    localparam logic [2:0] OP_SHL1 = 3'b101;
    localparam logic [2:0] OP_SAR1 = 3'b110;

    logic [NBITS_D-1:0] r_acc    [N_ACC];
    logic [NBITS_D-1:0] r_shadow [N_ACC];
    logic               r_zero;
    logic               r_neg;
    logic               r_ovf;

    logic               w_sel_ok;
    logic [NSEL-1:0]    w_idx;
    logic [NBITS_D-1:0] w_a;
    logic [NBITS_D:0]   w_sum;
    logic [NBITS_D:0]   w_dif;
    logic [NBITS_D-1:0] w_raw;
    logic [NBITS_D-1:0] w_result;
    logic               w_ovf;
    logic               w_true_neg;
    logic               w_op_valid;
    logic               w_exec;

    // Saturation bound: signed min when the true result is negative, else signed max.
    function automatic logic [NBITS_D-1:0] f_sat(input logic neg);
        if (neg) begin
            f_sat = {1'b1, {(NBITS_D-1){1'b0}}};
        end else begin
            f_sat = {1'b0, {(NBITS_D-1){1'b1}}};
        end
    endfunction

    // Out-of-range selects exist only when N_ACC is not a power of two.
    if (N_ACC == (1 << NSEL)) begin : g_pow2
        assign w_sel_ok = 1'b1;
    end else begin : g_npow2
        assign w_sel_ok = (32'(i_sel) < N_ACC);
    end

    assign w_idx  = w_sel_ok ? i_sel : {NSEL{1'b0}};
    assign w_a    = r_acc[w_idx];
    assign w_sum  = {w_a[MSB], w_a} + {i_data[MSB], i_data};
    assign w_dif  = {w_a[MSB], w_a} - {i_data[MSB], i_data};
    assign w_exec = i_wr && w_op_valid && !i_restore && w_sel_ok;

    // Op decode: raw result, signed-overflow flag and sign of the untruncated result.
    always_comb begin
        w_op_valid = 1'b1;
        w_raw      = w_a;
        w_ovf      = 1'b0;
        w_true_neg = 1'b0;
        case (i_op)
            OP_LOAD: w_raw = i_data;
            OP_ADD: begin
                w_raw      = w_sum[MSB:0];
                w_ovf      = (w_a[MSB] == i_data[MSB]) && (w_sum[MSB] != w_a[MSB]);
                w_true_neg = w_sum[NBITS_D];
            end
            OP_SUB: begin
                w_raw      = w_dif[MSB:0];
                w_ovf      = (w_a[MSB] != i_data[MSB]) && (w_dif[MSB] != w_a[MSB]);
                w_true_neg = w_dif[NBITS_D];
            end
            OP_CLR:  w_raw = {NBITS_D{1'b0}};
            OP_SHL1: begin
                w_raw      = {w_a[MSB-1:0], 1'b0};
                w_ovf      = w_a[MSB] ^ w_a[MSB-1];
                w_true_neg = w_a[MSB];
            end
            OP_SAR1: w_raw = {w_a[MSB], w_a[MSB:1]};
            default: w_op_valid = 1'b0;
        endcase
        if (SAT_EN && w_ovf) begin
            w_result = f_sat(w_true_neg);
        end else begin
            w_result = w_raw;
        end
    end

    // Bank, shadow and flag state; NBA ordering makes save+restore a swap.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int k = 0; k < N_ACC; k++) begin
                r_acc[k]    <= {NBITS_D{1'b0}};
                r_shadow[k] <= {NBITS_D{1'b0}};
            end
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (i_save) begin
                r_shadow <= r_acc;
            end
            if (i_restore) begin
                r_acc <= r_shadow;
            end else if (w_exec) begin
                r_acc[w_idx] <= w_result;
                r_zero       <= (w_result == {NBITS_D{1'b0}});
                r_neg        <= w_result[MSB];
                r_ovf        <= w_ovf;
            end
        end
    end

    assign o_acc  = w_sel_ok ? r_acc[w_idx] : {NBITS_D{1'b0}};
    assign o_zero = r_zero;
    assign o_neg  = r_neg;
    assign o_ovf  = r_ovf;

endmodule
